// File: rtl/serial_tx_transceiver_pkg.sv
// Shared definitions for the serial transmit path:
// FSM state encoding and line levels.
package serial_tx_transceiver_pkg;
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] START = 2'b01;
    localparam logic [1:0] DATA  = 2'b10;
    localparam logic [1:0] STOP  = 2'b11;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
endpackage

// File: rtl/serial_tx_transceiver_baud_tick_gen.sv
// Bit-period counter producing a one-cycle tick on the
// last clock of each serial bit.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/serial_tx_transceiver.sv
// Parallel-in/serial-out framed transmitter: start bit,
// LSB-first data, stop bit, with completion and overrun flags.
module serial_tx_transceiver #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  SampleData,
    input  logic                  TransferData,
    input  logic [DATA_WIDTH-1:0] DataIn,
    output logic                  SerialOut,
    output logic                  TransferDone,
    output logic                  TxActive,
    output logic                  Overrun
);
    import serial_tx_transceiver_pkg::*;

    localparam int BCW = $clog2(DATA_WIDTH + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] hold;
    logic [DATA_WIDTH-1:0] shift;
    logic [BCW-1:0]        bit_cnt;
    logic                  tick;
    logic                  accept;
    logic                  line;

    assign TxActive = (state != IDLE);
    assign accept   = (state == IDLE) && TransferData;

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .Clk   (Clk),
        .Reset (Reset),
        .clear (state == IDLE),
        .enable(TxActive),
        .tick  (tick)
    );

    // Line level for the current state; registered below so the
    // output lags the state by one clock.
    always_comb begin
        line = LINE_IDLE;
        unique case (state)
            IDLE:    line = LINE_IDLE;
            START:   line = START_BIT;
            DATA:    line = shift[0];
            default: line = STOP_BIT;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hold <= '0;
        end else if (SampleData) begin
            hold <= DataIn;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            shift     <= '0;
            bit_cnt   <= '0;
            SerialOut <= LINE_IDLE;
        end else begin
            SerialOut <= line;
            unique case (state)
                IDLE: begin
                    if (TransferData) begin
                        shift   <= SampleData ? DataIn : hold;
                        bit_cnt <= '0;
                        state   <= START;
                    end
                end
                START: begin
                    if (tick) state <= DATA;
                end
                DATA: begin
                    if (tick) begin
                        shift   <= shift >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) state <= STOP;
                    end
                end
                default: begin
                    if (tick) state <= IDLE;
                end
            endcase
        end
    end

    // Completion beats a coincident SampleData clear.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            TransferDone <= 1'b0;
        end else if (state == STOP && tick) begin
            TransferDone <= 1'b1;
        end else if (SampleData || accept) begin
            TransferDone <= 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Overrun <= 1'b0;
        end else if (accept) begin
            Overrun <= 1'b0;
        end else if (TransferData && TxActive) begin
            Overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_serial_tx_transceiver.sv
// Self-checking bench for serial_tx_transceiver: vector table,
// random frames against a frame model, and a CLKS_PER_BIT=1 case.
module tb_serial_tx_transceiver;
    localparam int W   = 8;
    localparam int CPB = 4;
    localparam int N   = (W + 2) * CPB;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sd, td;
    logic [W-1:0] din;
    logic         so, done, act, ovr;

    logic       sd1, td1;
    logic [3:0] din1;
    logic       so1, done1, act1, ovr1;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    serial_tx_transceiver #(
        .DATA_WIDTH  (W),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .Clk         (clk),
        .Reset       (rst),
        .SampleData  (sd),
        .TransferData(td),
        .DataIn      (din),
        .SerialOut   (so),
        .TransferDone(done),
        .TxActive    (act),
        .Overrun     (ovr)
    );

    serial_tx_transceiver #(
        .DATA_WIDTH  (4),
        .CLKS_PER_BIT(1)
    ) dut1 (
        .Clk         (clk),
        .Reset       (rst),
        .SampleData  (sd1),
        .TransferData(td1),
        .DataIn      (din1),
        .SerialOut   (so1),
        .TransferDone(done1),
        .TxActive    (act1),
        .Overrun     (ovr1)
    );

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // mode 0: load then transfer; 1: bypass; 2: transfer from hold.
    // frame[i] is the i-th line bit sent (start first).
    task automatic send(input logic [W-1:0] d, input int mode,
                        input logic [W+1:0] frame, input int inj_k,
                        input int rst_k);
        if (mode == 0) begin
            sd = 1'b1;
            din = d;
            @(negedge clk);
            chk("done_clear", done, 0);
            sd = 1'b0;
            din = ~d;
        end else if (mode == 1) begin
            sd = 1'b1;
            din = d;
        end else begin
            din = ~d;
        end
        td = 1'b1;
        @(negedge clk);
        td = 1'b0;
        sd = 1'b0;
        chk("accept_line", so, 1);
        chk("accept_active", act, 1);
        chk("accept_done", done, 0);
        chk("accept_overrun", ovr, 0);
        for (int k = 1; k <= N; k++) begin
            if (k == rst_k) begin
                rst = 1'b1;
                #1;
                chk("rst_line", so, 1);
                chk("rst_done", done, 0);
                chk("rst_active", act, 0);
                chk("rst_overrun", ovr, 0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            @(negedge clk);
            chk("line", so, frame[(k-1)/CPB]);
            chk("active", act, k < N);
            chk("done", done, k == N);
            if (k == inj_k) begin
                sd = 1'b1;
                din = 8'hFF;
                td = 1'b1;
            end else if (k == inj_k + 1) begin
                sd = 1'b0;
                td = 1'b0;
            end
        end
        if (inj_k > 0) chk("overrun", ovr, 1);
    endtask

    typedef struct {
        logic [W-1:0] data;
        int           mode;
        logic [W+1:0] frame;
        int           inj_k;
        int           rst_k;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [W-1:0] d;
        logic [5:0]   f1;

        vecs[0] = '{8'hA5, 0, 10'b1101001010, -1, -1};
        vecs[1] = '{8'h3C, 0, 10'b1001111000, 1 + CPB * 4, -1};
        vecs[2] = '{8'hFF, 2, 10'b1111111110, -1, -1};
        vecs[3] = '{8'h81, 1, 10'b1100000010, -1, -1};
        vecs[4] = '{8'hC3, 0, 10'b1110000110, -1, 1 + CPB * 5};
        vecs[5] = '{8'h5A, 0, 10'b1010110100, -1, -1};

        sd = 0; td = 0; din = '0;
        sd1 = 0; td1 = 0; din1 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_line", so, 1);
            chk("idle_done", done, 0);
            chk("idle_active", act, 0);
            chk("idle_overrun", ovr, 0);
        end

        for (int i = 0; i < 6; i++) begin
            send(vecs[i].data, vecs[i].mode, vecs[i].frame,
                 vecs[i].inj_k, vecs[i].rst_k);
        end

        for (int i = 0; i < 20; i++) begin
            d = W'($urandom);
            send(d, int'($urandom_range(0, 1)), {1'b1, d, 1'b0}, -1, -1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        f1 = 6'b101100;
        sd1 = 1'b1;
        din1 = 4'h6;
        @(negedge clk);
        sd1 = 1'b0;
        din1 = 4'h0;
        td1 = 1'b1;
        @(negedge clk);
        td1 = 1'b0;
        chk("c1_accept_active", act1, 1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("c1_line", so1, f1[k-1]);
            chk("c1_done", done1, k == 6);
            chk("c1_active", act1, k < 6);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule
